lpc_encode_sequencer: RTL and testbench
=======================================

Name: lpc_encode_sequencer

Overview:
Parametrised top-level sequencer for the LPC encoder. It runs autocorrelation, Levinson-Durbin and the inverse filter in order, then hands the frame buffer to the external reader. Compared with the single-shot controller, it adds:
- an explicit autocorrelation start pulse;
- a per-stage watchdog with a sticky error state;
- abort;
- continuous multi-frame mode;
- a completed-frame counter.

It sits between the external memory port and the three compute engines and drives their start/reset strobes and the memory read-select muxes.

Parameters:
- FRAME_CNT_W, 16, width of the completed-frame counter; wraps modulo 2^FRAME_CNT_W.
- TIMEOUT_CYCLES, 4096, maximum cycles allowed in any RUN state before error; 0 disables the watchdog.
- TIMEOUT_W, 13, watchdog counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin a frame; sampled in IDLE only.
- continuous, input, 1, when 1, DONE+rfin loops to a new frame instead of IDLE.
- rfin, input, 1, external reader finished with the results.
- abort, input, 1, cancel the current frame.
- err_clr, input, 1, leave ERROR.
- ready_autocorrelation, input, 1, autocorrelation complete (level or pulse).
- ready_levinson, input, 1, Levinson complete.
- ready_ifilter, input, 1, inverse filter complete.
- start_autocorrelation, output, 1, 1-cycle start pulse.
- reset_levinson, output, 1, 1-cycle start/reset pulse.
- reset_ifilter, output, 1, 1-cycle start/reset pulse.
- a_rsel_sel, output, 2, coefficient memory read select: 0 = Levinson, 1 = ifilter, 2 = external.
- x_raddr_sel, output, 1, sample memory read address select: 0 = autocorrelation, 1 = ifilter.
- rready, output, 1, results readable by the external port.
- busy, output, 1, high in any state other than IDLE, DONE and ERROR.
- error, output, 1, high in ERROR.
- err_stage, output, 2, stage that timed out: 1 = AC, 2 = LV, 3 = IF; 0 = none.
- frame_count, output, FRAME_CNT_W, number of completed frames.

Behaviour:
- Moore FSM with a registered state; outputs decode from the state, except frame_count and err_stage, which are registered.
- States: IDLE, AC_ST, AC_RUN, LV_ST, LV_RUN, IF_ST, IF_RUN, DONE, ERROR.
- Output decode per state (all outputs defined in every state, no X):
  - IDLE: a_rsel_sel = 2, x_raddr_sel = 0, all strobes 0.
  - AC_ST: start_autocorrelation = 1, a_rsel_sel = 2, x_raddr_sel = 0.
  - AC_RUN: a_rsel_sel = 2, x_raddr_sel = 0.
  - LV_ST: reset_levinson = 1, a_rsel_sel = 0, x_raddr_sel = 0.
  - LV_RUN: a_rsel_sel = 0, x_raddr_sel = 0.
  - IF_ST: reset_ifilter = 1, a_rsel_sel = 1, x_raddr_sel = 1.
  - IF_RUN: a_rsel_sel = 1, x_raddr_sel = 1.
  - DONE: rready = 1, a_rsel_sel = 2, x_raddr_sel = 0.
  - ERROR: error = 1, a_rsel_sel = 2, x_raddr_sel = 0.
- Transitions:
  - IDLE -start-> AC_ST.
  - Each *_ST state moves unconditionally to its *_RUN state after 1 cycle.
  - AC_RUN -ready_autocorrelation-> LV_ST; LV_RUN -ready_levinson-> IF_ST; IF_RUN -ready_ifilter-> DONE.
  - DONE -rfin-> AC_ST if continuous, else IDLE.
  - ERROR -err_clr-> IDLE.
  - Ready inputs are ignored outside their own RUN state.
- Watchdog:
  - Counter clears to 0 on entry to every RUN state and increments each cycle spent in RUN.
  - If it reaches TIMEOUT_CYCLES-1 without the matching ready, the next state is ERROR and err_stage is loaded with the stage code.
  - If ready is asserted in the expiry cycle, ready wins.
- Abort:
  - In AC_ST..IF_RUN or DONE, abort forces the next state to IDLE.
  - Abort has priority over ready, rfin and timeout; it is ignored in IDLE and ERROR.
  - frame_count is unchanged by abort.
- ERROR:
  - start and abort are ignored; err_clr returns to IDLE and clears err_stage to 0.
  - err_stage holds its value until err_clr or reset.
- frame_count increments by 1 (mod 2^FRAME_CNT_W) on the IF_RUN->DONE transition only.
- Latencies:
  - start to start_autocorrelation: 1 cycle.
  - Ready to the next stage's strobe: 1 cycle.
  - ready_ifilter to rready: 1 cycle.
  - Continuous-mode rfin to start_autocorrelation: 1 cycle.
- Reset, from any state including mid-frame: state = IDLE, watchdog counter = 0, frame_count = 0, err_stage = 0. The resulting output values are start_autocorrelation = 0, reset_levinson = 0, reset_ifilter = 0, rready = 0, busy = 0, error = 0, a_rsel_sel = 2, x_raddr_sel = 0.
- An illegal state encoding transitions to IDLE.

Decomposition:
- Shared package lpc_pkg holds:
  - the state enum;
  - the a_rsel_sel codes RSEL_LEV = 0, RSEL_IFIL = 1, RSEL_EXT = 2;
  - the x_raddr_sel codes XSEL_AC = 0, XSEL_IF = 1;
  - the err_stage codes.
- One sub-module, lpc_stage_watchdog, holds the counter, clear-on-entry logic, the expired flag and the TIMEOUT_CYCLES = 0 bypass.

Test Plan:
- Nominal frame: start@t0, each ready 5 cycles after its strobe, rfin 3 cycles after rready, continuous = 0.
  - start_autocorrelation at t1, followed by reset_levinson and reset_ifilter pulses of exactly 1 cycle each.
  - rready lasts 4 cycles, then the FSM returns to IDLE and frame_count = 1.
- Continuous mode: continuous = 1, 3 frames run back to back.
  - start_autocorrelation fires 1 cycle after each rfin, with no IDLE visited.
  - frame_count = 3, and busy is low only during DONE.
- Watchdog: TIMEOUT_CYCLES = 16, ready_levinson never asserted.
  - error rises 16 cycles after entering LV_RUN, err_stage = 2.
  - err_clr returns the FSM to IDLE with err_stage = 0.
  - A following start runs normally.
- Ready in the expiry cycle: ready_ifilter asserted on the 16th IF_RUN cycle → DONE, error stays 0.
- Abort:
  - Abort in LV_RUN together with ready_levinson → IDLE, no reset_ifilter pulse, frame_count unchanged.
  - Abort in DONE → IDLE.
- Mid-operation reset asserted in IF_RUN → all outputs return to their reset values the next cycle and frame_count = 0. The same check is repeated with frame_count = 0xFFFF wrapping to 0 after one more completed frame.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types and select/stage codes for the LPC encoder sequencer.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_AC_ST  = 4'd1,
    ST_AC_RUN = 4'd2,
    ST_LV_ST  = 4'd3,
    ST_LV_RUN = 4'd4,
    ST_IF_ST  = 4'd5,
    ST_IF_RUN = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERROR  = 4'd8
  } lpc_state_e;

  localparam logic [1:0] RSEL_LEV  = 2'd0;
  localparam logic [1:0] RSEL_IFIL = 2'd1;
  localparam logic [1:0] RSEL_EXT  = 2'd2;

  localparam logic XSEL_AC = 1'b0;
  localparam logic XSEL_IF = 1'b1;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_AC   = 2'd1;
  localparam logic [1:0] ERR_LV   = 2'd2;
  localparam logic [1:0] ERR_IF   = 2'd3;

endpackage

// File: rtl/lpc_stage_watchdog.sv
// Per-stage cycle counter: cleared while a start strobe is issued, counts every
// RUN cycle, and flags expiry in the last allowed RUN cycle.
module lpc_stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != '1)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_bypass
      assign expired = 1'b0;
    end else begin : g_active
      assign expired = run && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/lpc_encode_sequencer.sv
// Top-level LPC encode sequencer: autocorrelation -> Levinson -> inverse filter
// -> hand-off, with watchdog, abort, continuous mode and a frame counter.
module lpc_encode_sequencer
  import lpc_pkg::*;
#(
  parameter int FRAME_CNT_W    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   rfin,
  input  logic                   abort,
  input  logic                   err_clr,
  input  logic                   ready_autocorrelation,
  input  logic                   ready_levinson,
  input  logic                   ready_ifilter,
  output logic                   start_autocorrelation,
  output logic                   reset_levinson,
  output logic                   reset_ifilter,
  output logic [1:0]             a_rsel_sel,
  output logic                   x_raddr_sel,
  output logic                   rready,
  output logic                   busy,
  output logic                   error,
  output logic [1:0]             err_stage,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  lpc_state_e             state_q, state_d;
  logic [1:0]             err_stage_q, err_stage_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic wd_clear;
  logic wd_run;
  logic wd_expired;

  assign wd_clear = (state_q == ST_AC_ST) || (state_q == ST_LV_ST) || (state_q == ST_IF_ST);
  assign wd_run   = (state_q == ST_AC_RUN) || (state_q == ST_LV_RUN) || (state_q == ST_IF_RUN);

  lpc_stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(wd_expired)
  );

  // Priority inside each RUN state: abort, then ready, then timeout.
  always_comb begin
    state_d       = state_q;
    err_stage_d   = err_stage_q;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_AC_ST;
      end
      ST_AC_ST:  state_d = abort ? ST_IDLE : ST_AC_RUN;
      ST_AC_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready_autocorrelation) begin
          state_d = ST_LV_ST;
        end else if (wd_expired) begin
          state_d     = ST_ERROR;
          err_stage_d = ERR_AC;
        end
      end
      ST_LV_ST:  state_d = abort ? ST_IDLE : ST_LV_RUN;
      ST_LV_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready_levinson) begin
          state_d = ST_IF_ST;
        end else if (wd_expired) begin
          state_d     = ST_ERROR;
          err_stage_d = ERR_LV;
        end
      end
      ST_IF_ST:  state_d = abort ? ST_IDLE : ST_IF_RUN;
      ST_IF_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready_ifilter) begin
          state_d       = ST_DONE;
          frame_count_d = frame_count_q + FRAME_CNT_W'(1);
        end else if (wd_expired) begin
          state_d     = ST_ERROR;
          err_stage_d = ERR_IF;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rfin) begin
          state_d = continuous ? ST_AC_ST : ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (err_clr) begin
          state_d     = ST_IDLE;
          err_stage_d = ERR_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      err_stage_q   <= ERR_NONE;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      err_stage_q   <= err_stage_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    start_autocorrelation = 1'b0;
    reset_levinson        = 1'b0;
    reset_ifilter         = 1'b0;
    rready                = 1'b0;
    busy                  = 1'b0;
    error                 = 1'b0;
    a_rsel_sel            = RSEL_EXT;
    x_raddr_sel           = XSEL_AC;
    case (state_q)
      ST_AC_ST: begin
        start_autocorrelation = 1'b1;
        busy                  = 1'b1;
      end
      ST_AC_RUN: busy = 1'b1;
      ST_LV_ST: begin
        reset_levinson = 1'b1;
        busy           = 1'b1;
        a_rsel_sel     = RSEL_LEV;
      end
      ST_LV_RUN: begin
        busy       = 1'b1;
        a_rsel_sel = RSEL_LEV;
      end
      ST_IF_ST: begin
        reset_ifilter = 1'b1;
        busy          = 1'b1;
        a_rsel_sel    = RSEL_IFIL;
        x_raddr_sel   = XSEL_IF;
      end
      ST_IF_RUN: begin
        busy        = 1'b1;
        a_rsel_sel  = RSEL_IFIL;
        x_raddr_sel = XSEL_IF;
      end
      ST_DONE:  rready = 1'b1;
      ST_ERROR: error  = 1'b1;
      default: ;
    endcase
  end

  assign err_stage   = err_stage_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lpc_encode_sequencer.sv
// Directed self-checking bench for lpc_encode_sequencer (watchdog set to 16 cycles;
// a second 2-bit-counter instance exercises frame counter wrap).
module tb_lpc_encode_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic rfin = 1'b0;
  logic abort = 1'b0;
  logic err_clr = 1'b0;
  logic ready_autocorrelation = 1'b0;
  logic ready_levinson = 1'b0;
  logic ready_ifilter = 1'b0;

  logic        start_autocorrelation, reset_levinson, reset_ifilter;
  logic [1:0]  a_rsel_sel;
  logic        x_raddr_sel, rready, busy, error;
  logic [1:0]  err_stage;
  logic [15:0] frame_count;

  logic        w2_sa, w2_rl, w2_ri, w2_xsel, w2_rready, w2_busy, w2_error;
  logic [1:0]  w2_rsel, w2_err_stage, w2_frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_fc   = 0;

  always #5 clk = ~clk;

  lpc_encode_sequencer #(.FRAME_CNT_W(16), .TIMEOUT_CYCLES(16), .TIMEOUT_W(13)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .rfin(rfin),
    .abort(abort), .err_clr(err_clr),
    .ready_autocorrelation(ready_autocorrelation), .ready_levinson(ready_levinson),
    .ready_ifilter(ready_ifilter),
    .start_autocorrelation(start_autocorrelation), .reset_levinson(reset_levinson),
    .reset_ifilter(reset_ifilter), .a_rsel_sel(a_rsel_sel), .x_raddr_sel(x_raddr_sel),
    .rready(rready), .busy(busy), .error(error), .err_stage(err_stage),
    .frame_count(frame_count)
  );

  lpc_encode_sequencer #(.FRAME_CNT_W(2), .TIMEOUT_CYCLES(16), .TIMEOUT_W(13)) dut_w2 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .rfin(rfin),
    .abort(abort), .err_clr(err_clr),
    .ready_autocorrelation(ready_autocorrelation), .ready_levinson(ready_levinson),
    .ready_ifilter(ready_ifilter),
    .start_autocorrelation(w2_sa), .reset_levinson(w2_rl), .reset_ifilter(w2_ri),
    .a_rsel_sel(w2_rsel), .x_raddr_sel(w2_xsel), .rready(w2_rready), .busy(w2_busy),
    .error(w2_error), .err_stage(w2_err_stage), .frame_count(w2_frame_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] strobes();
    return {start_autocorrelation, reset_levinson, reset_ifilter};
  endfunction

  function automatic logic [1:0] exp_rsel(input int which);
    case (which)
      0:       return 2'd2;
      1:       return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  task automatic set_ready(input int which, input logic v);
    case (which)
      0:       ready_autocorrelation = v;
      1:       ready_levinson = v;
      default: ready_ifilter = v;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_strobes"}, 32'(strobes()), 0);
    check_val({tag, "_rready"}, 32'(rready), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_error"}, 32'(error), 0);
    check_val({tag, "_rsel"}, 32'(a_rsel_sel), 2);
    check_val({tag, "_xsel"}, 32'(x_raddr_sel), 0);
    check_val({tag, "_err_stage"}, 32'(err_stage), 0);
    check_val({tag, "_fc"}, 32'(frame_count), 0);
    check_val({tag, "_fc_w2"}, 32'(w2_frame_count), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_fc = 0;
    check_reset_outputs("reset");
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered in the ST cycle of a stage; ready is raised dly cycles after the strobe.
  task automatic stage(input int which, input int dly);
    check_val($sformatf("st%0d_strobes", which), 32'(strobes()), 32'(3'b100 >> which));
    check_val($sformatf("st%0d_busy", which), 32'(busy), 1);
    check_val($sformatf("st%0d_rsel", which), 32'(a_rsel_sel), 32'(exp_rsel(which)));
    check_val($sformatf("st%0d_xsel", which), 32'(x_raddr_sel), 32'(which == 2));
    for (int i = 0; i < dly; i++) begin
      tick();
      check_val($sformatf("run%0d_strobes", which), 32'(strobes()), 0);
      check_val($sformatf("run%0d_busy", which), 32'(busy), 1);
      check_val($sformatf("run%0d_rsel", which), 32'(a_rsel_sel), 32'(exp_rsel(which)));
    end
    set_ready(which, 1'b1);
    tick();
    set_ready(which, 1'b0);
  endtask

  task automatic frame_body(input int dly);
    stage(0, dly);
    stage(1, dly);
    stage(2, dly);
    exp_fc++;
  endtask

  task automatic done_phase(input int rdly, input logic cont);
    check_val("done_rready", 32'(rready), 1);
    check_val("done_busy", 32'(busy), 0);
    check_val("done_error", 32'(error), 0);
    check_val("done_rsel", 32'(a_rsel_sel), 2);
    check_val("done_xsel", 32'(x_raddr_sel), 0);
    check_val("done_fc", 32'(frame_count), 32'(exp_fc & 32'hFFFF));
    check_val("done_fc_w2", 32'(w2_frame_count), 32'(exp_fc % 4));
    for (int i = 0; i < rdly; i++) begin
      tick();
      check_val("done_rready_hold", 32'(rready), 1);
    end
    continuous = cont;
    rfin = 1'b1;
    tick();
    rfin = 1'b0;
    if (cont) begin
      check_val("cont_restart_strobes", 32'(strobes()), 32'(3'b100));
      check_val("cont_restart_busy", 32'(busy), 1);
    end else begin
      check_val("idle_rready", 32'(rready), 0);
      check_val("idle_busy", 32'(busy), 0);
      check_val("idle_strobes", 32'(strobes()), 0);
    end
    $display("frame complete: frame_count=%0d expected=%0d", frame_count, exp_fc);
  endtask

  // Entered in the ST cycle; expects error after 16 RUN cycles with no ready.
  task automatic expect_timeout(input logic [1:0] code);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val("wd_no_error_yet", 32'(error), 0);
    end
    tick();
    check_val("wd_error", 32'(error), 1);
    check_val("wd_err_stage", 32'(err_stage), 32'(code));
    check_val("wd_busy", 32'(busy), 0);
    check_val("wd_rsel", 32'(a_rsel_sel), 2);
    $display("timeout: err_stage=%0d expected=%0d", err_stage, code);
  endtask

  task automatic clear_error(input logic [1:0] code);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_val("err_ignores_start_abort", 32'(error), 1);
    check_val("err_stage_hold", 32'(err_stage), 32'(code));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("err_clr_error", 32'(error), 0);
    check_val("err_clr_stage", 32'(err_stage), 0);
    check_val("err_clr_busy", 32'(busy), 0);
    tick();
    check_val("err_clr_idle_strobes", 32'(strobes()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    tick();
    tick();
    do_reset();

    // Nominal frame: readies 5 cycles after strobes, rfin 3 cycles after rready.
    start_frame();
    frame_body(5);
    done_phase(3, 1'b0);
    check_val("nominal_fc", 32'(frame_count), 1);

    // Continuous mode: three back-to-back frames without visiting IDLE.
    do_reset();
    start_frame();
    for (int f = 0; f < 3; f++) begin
      frame_body(1);
      done_phase(1, f < 2);
    end
    check_val("cont_fc", 32'(frame_count), 3);

    // Watchdog in Levinson, then a normal frame.
    start_frame();
    stage(0, 1);
    expect_timeout(2'd2);
    clear_error(2'd2);
    start_frame();
    frame_body(2);
    done_phase(1, 1'b0);

    // Watchdog in autocorrelation and in inverse filter.
    start_frame();
    expect_timeout(2'd1);
    clear_error(2'd1);
    start_frame();
    stage(0, 1);
    stage(1, 1);
    expect_timeout(2'd3);
    clear_error(2'd3);

    // Ready in the expiry cycle wins over the timeout.
    start_frame();
    stage(0, 1);
    stage(1, 1);
    stage(2, 16);
    exp_fc++;
    check_val("expiry_ready_error", 32'(error), 0);
    done_phase(1, 1'b0);

    // Abort in LV_RUN together with ready_levinson.
    start_frame();
    stage(0, 1);
    tick();
    abort = 1'b1;
    ready_levinson = 1'b1;
    tick();
    abort = 1'b0;
    ready_levinson = 1'b0;
    check_val("abort_lv_busy", 32'(busy), 0);
    check_val("abort_lv_strobes", 32'(strobes()), 0);
    tick();
    check_val("abort_lv_no_ifilter", 32'(strobes()), 0);
    check_val("abort_lv_fc", 32'(frame_count), 32'(exp_fc));
    $display("abort in LV_RUN: frame_count=%0d", frame_count);

    // Abort in DONE beats rfin with continuous set.
    start_frame();
    frame_body(1);
    check_val("pre_abort_done_rready", 32'(rready), 1);
    continuous = 1'b1;
    rfin = 1'b1;
    abort = 1'b1;
    tick();
    rfin = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    check_val("abort_done_rready", 32'(rready), 0);
    check_val("abort_done_strobes", 32'(strobes()), 0);
    check_val("abort_done_busy", 32'(busy), 0);
    check_val("abort_done_fc", 32'(frame_count), 32'(exp_fc));
    $display("abort in DONE: frame_count=%0d", frame_count);

    // Reset mid-frame in IF_RUN.
    start_frame();
    stage(0, 1);
    stage(1, 1);
    tick();
    check_val("pre_reset_busy", 32'(busy), 1);
    do_reset();

    // Bring the narrow counter to all-ones, reset in IF_RUN, then wrap it.
    for (int f = 0; f < 3; f++) begin
      start_frame();
      frame_body(1);
      done_phase(1, 1'b0);
    end
    check_val("w2_at_max", 32'(w2_frame_count), 3);
    start_frame();
    stage(0, 1);
    stage(1, 1);
    tick();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      start_frame();
      frame_body(1);
      done_phase(1, 1'b0);
    end
    check_val("w2_wrapped", 32'(w2_frame_count), 0);
    check_val("wide_after_wrap", 32'(frame_count), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
